// File: rtl/bits_sync_pkg.sv
// Shared definitions for the per-bit level synchroniser/filter (bits_sync_filt).
// Filter counter width helper, per-bit filter state type and parameter lower bounds.
package bits_sync_pkg;

  localparam int unsigned MIN_RETIME = 2;
  localparam int unsigned MIN_FILT   = 1;

  // Registered filter outputs of one channel: current level and its change pulse.
  typedef struct packed {
    logic data;
    logic chg;
  } filt_state_t;

  function automatic int unsigned cnt_w(input int unsigned filt);
    int unsigned w;
    w = $clog2(filt);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bits_sync_filt_ch.sv
// One channel of bits_sync_filt: retiming chain, hold-time filter, output/pulse registers.
// Edge pulse outputs exist only when BITS_SYNC_EDGE_EN is defined.
module bits_sync_filt_ch
  import bits_sync_pkg::*;
#(
  parameter int unsigned NUM_RETIME  = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic i_clk_b,
  input  logic i_rstn_b,
  input  logic i_data_a,
  output logic o_data_b,
`ifdef BITS_SYNC_EDGE_EN
  output logic o_rise_b,
  output logic o_fall_b,
`endif
  output logic o_chg_b
);

  localparam int unsigned     CNT_W   = cnt_w(FILT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  generate
    if (NUM_RETIME < MIN_RETIME) begin : g_bad_retime
      $error("bits_sync_filt_ch: NUM_RETIME must be >= 2");
    end
    if (FILT_CYCLES < MIN_FILT) begin : g_bad_filt
      $error("bits_sync_filt_ch: FILT_CYCLES must be >= 1");
    end
  endgenerate

  (* ASYNC_REG = "TRUE" *) logic [NUM_RETIME-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  filt_state_t            st_q, st_d;

  always_ff @(posedge i_clk_b) begin
    if (!i_rstn_b) begin
      sync_q <= {NUM_RETIME{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[NUM_RETIME-2:0], i_data_a};
    end
  end

  assign sync = sync_q[NUM_RETIME-1];

  // Counter saturates at CNT_MAX by construction: reaching it either commits or clears.
  always_comb begin
    cnt_d      = '0;
    st_d.data  = st_q.data;
    st_d.chg   = 1'b0;
    if (sync != st_q.data) begin
      if (cnt_q == CNT_MAX) begin
        st_d.data = sync;
        st_d.chg  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk_b) begin
    if (!i_rstn_b) begin
      cnt_q <= '0;
      st_q  <= '{data: RESET_VAL, chg: 1'b0};
    end else begin
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign o_data_b = st_q.data;
  assign o_chg_b  = st_q.chg;

`ifdef BITS_SYNC_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge i_clk_b) begin
    if (!i_rstn_b) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= st_d.chg &  st_d.data;
      fall_q <= st_d.chg & ~st_d.data;
    end
  end

  assign o_rise_b = rise_q;
  assign o_fall_b = fall_q;
`endif

endmodule

// File: rtl/bits_sync_filt.sv
// Per-bit synchroniser + glitch filter for BUS_WIDTH independent asynchronous levels.
// Optional macro BITS_SYNC_EDGE_EN adds registered o_rise_b/o_fall_b pulse outputs.
module bits_sync_filt
  import bits_sync_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH   = 1,
  parameter int unsigned          NUM_RETIME  = 2,
  parameter int unsigned          FILT_CYCLES = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                 i_clk_b,
  input  logic                 i_rstn_b,
  input  logic [BUS_WIDTH-1:0] i_data_a,
  output logic [BUS_WIDTH-1:0] o_data_b,
`ifdef BITS_SYNC_EDGE_EN
  output logic [BUS_WIDTH-1:0] o_rise_b,
  output logic [BUS_WIDTH-1:0] o_fall_b,
`endif
  output logic [BUS_WIDTH-1:0] o_chg_b
);

  generate
    if (BUS_WIDTH < 1) begin : g_bad_width
      $error("bits_sync_filt: BUS_WIDTH must be >= 1");
    end

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_ch
`ifdef BITS_SYNC_EDGE_EN
      bits_sync_filt_ch #(
        .NUM_RETIME  (NUM_RETIME),
        .FILT_CYCLES (FILT_CYCLES),
        .RESET_VAL   (RESET_VAL[i])
      ) u_ch (
        .i_clk_b  (i_clk_b),
        .i_rstn_b (i_rstn_b),
        .i_data_a (i_data_a[i]),
        .o_data_b (o_data_b[i]),
        .o_rise_b (o_rise_b[i]),
        .o_fall_b (o_fall_b[i]),
        .o_chg_b  (o_chg_b[i])
      );
`else
      bits_sync_filt_ch #(
        .NUM_RETIME  (NUM_RETIME),
        .FILT_CYCLES (FILT_CYCLES),
        .RESET_VAL   (RESET_VAL[i])
      ) u_ch (
        .i_clk_b  (i_clk_b),
        .i_rstn_b (i_rstn_b),
        .i_data_a (i_data_a[i]),
        .o_data_b (o_data_b[i]),
        .o_chg_b  (o_chg_b[i])
      );
`endif
    end
  endgenerate

endmodule

// File: tb/tb_bits_sync_filt.sv
// Bench for bits_sync_filt: directed scenarios with literal expectations plus random levels
// checked every cycle against a delay-line / hold-window reference model.
module tb_bits_sync_filt;

  localparam int unsigned W    = 4;
  localparam int unsigned NRT  = 2;
  localparam int unsigned FILT = 4;
  localparam logic [W-1:0] RV  = 4'b0100;

  logic         clk;
  logic         rstn;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic [W-1:0] chg_b;
`ifdef BITS_SYNC_EDGE_EN
  logic [W-1:0] rise_b;
  logic [W-1:0] fall_b;
`endif

  int checks = 0;
  int errors = 0;

  bits_sync_filt #(
    .BUS_WIDTH   (W),
    .NUM_RETIME  (NRT),
    .FILT_CYCLES (FILT),
    .RESET_VAL   (RV)
  ) dut (
    .i_clk_b  (clk),
    .i_rstn_b (rstn),
    .i_data_a (data_a),
    .o_data_b (data_b),
`ifdef BITS_SYNC_EDGE_EN
    .o_rise_b (rise_b),
    .o_fall_b (fall_b),
`endif
    .o_chg_b  (chg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: synced value is the input seen NRT edges earlier; an output bit
  // flips once the last FILT synced samples since reset all disagree with it.
  logic [W-1:0] dq[$];
  logic [W-1:0] fh[$];
  logic [W-1:0] m_data, m_chg, m_rise, m_fall;
  bit           m_valid = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      dq = {};
      for (int k = 0; k < NRT; k++) dq.push_back(RV);
      fh      = {};
      m_data  = RV;
      m_chg   = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_valid = 1;
    end else if (m_valid) begin
      logic [W-1:0] s;
      s = dq.pop_front();
      dq.push_back(data_a);
      fh.push_back(s);
      if (fh.size() > FILT) void'(fh.pop_front());
      m_chg = '0;
      for (int b = 0; b < W; b++) begin
        bit all_diff;
        all_diff = (fh.size() == FILT);
        foreach (fh[k]) if (fh[k][b] == m_data[b]) all_diff = 0;
        if (all_diff) begin
          m_data[b] = ~m_data[b];
          m_chg[b]  = 1'b1;
        end
      end
      m_rise = m_chg & m_data;
      m_fall = m_chg & ~m_data;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_data", data_b, m_data);
      chk("model_chg", chg_b, m_chg);
`ifdef BITS_SYNC_EDGE_EN
      chk("model_rise", rise_b, m_rise);
      chk("model_fall", fall_b, m_fall);
`endif
    end
  end

  int hold[W];

  initial begin
    rstn   = 1'b0;
    data_a = 4'b1011;

    // Reset holds RESET_VAL regardless of input, no pulses.
    repeat (5) begin
      @(negedge clk);
      chk("rst_data", data_b, RV);
      chk("rst_chg", chg_b, '0);
    end
    rstn   = 1'b1;
    data_a = 4'b0100;
    repeat (6) @(negedge clk);

    // Latency: bit0 step, update after E5 only.
    data_a = 4'b0101;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk("lat_data", data_b, (k >= 5) ? 4'b0101 : 4'b0100);
      chk("lat_chg", chg_b, (k == 5) ? 4'b0001 : 4'b0000);
    end

    // Glitch: 3-cycle pulse on bit1 is rejected.
    data_a = 4'b0111;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) data_a = 4'b0101;
      chk("glitch3_data", data_b, 4'b0101);
      chk("glitch3_chg", chg_b, 4'b0000);
    end

    // 4-cycle pulse passes: rise after E5, fall after E9.
    data_a = 4'b0111;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k == 3) data_a = 4'b0101;
      chk("pulse4_data", data_b, (k >= 5 && k <= 8) ? 4'b0111 : 4'b0101);
      chk("pulse4_chg", chg_b, (k == 5 || k == 9) ? 4'b0010 : 4'b0000);
    end
    repeat (3) @(negedge clk);

    // Independence: bit0 fall + bit3 rise together, bit1 glitches for 2 cycles.
    data_a = 4'b1110;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) data_a = 4'b1100;
      chk("indep_data", data_b, (k >= 5) ? 4'b1100 : 4'b0101);
      chk("indep_chg", chg_b, (k == 5) ? 4'b1001 : 4'b0000);
    end
    repeat (3) @(negedge clk);

    // Mid-operation reset with filters part-way, then full latency again.
    data_a = 4'b0101;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("mid_pre_data", data_b, 4'b1100);
    end
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", data_b, RV);
    chk("mid_rst_chg", chg_b, '0);
    rstn = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk("mid_rel_data", data_b, (k >= 5) ? 4'b0101 : 4'b0100);
      chk("mid_rel_chg", chg_b, (k == 5) ? 4'b0001 : 4'b0000);
    end

`ifdef BITS_SYNC_EDGE_EN
    begin
      int n_rise, n_fall;
      n_rise = 0;
      n_fall = 0;
      data_a = 4'b0111;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (k == 9) data_a = 4'b0101;
        n_rise += $countones(rise_b);
        n_fall += $countones(fall_b);
      end
      chk("edge_rise_count", W'(n_rise), W'(1));
      chk("edge_fall_count", W'(n_fall), W'(1));
    end
`endif

    // Random levels with random hold lengths and occasional resets.
    for (int b = 0; b < W; b++) hold[b] = $urandom_range(1, 7);
    repeat (3000) begin
      @(negedge clk);
      rstn = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int b = 0; b < W; b++) begin
        hold[b] = hold[b] - 1;
        if (hold[b] == 0) begin
          data_a[b] = ~data_a[b];
          hold[b]   = $urandom_range(1, 7);
        end
      end
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
